// File: rtl/alu32_issue_ctrl_if.sv
// Handshake and ALU-side bus between the issue controller, its upstream
// producer, the structural ALU/mux bank and the downstream result consumer.
interface alu32_issue_ctrl_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] opa;
  logic [31:0] opb;
  logic [2:0]  sel;
  logic [31:0] alu_result;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;

  modport slave (
    input  in_valid, op, a, b, alu_result, out_ready,
    output in_ready, opa, opb, sel, out_valid, result, zero
  );

  modport master (
    output in_valid, op, a, b, alu_result, out_ready,
    input  in_ready, opa, opb, sel, out_valid, result, zero
  );
endinterface

// File: rtl/alu32_issue_ctrl.sv
// Issue stage for the 32-bit ALU: latches one op, holds operands/select for a
// settle window, then captures the mux output with a zero flag until consumed.
//
// state | meaning
// IDLE  | waiting for a request, in_ready high
// EXEC  | operands/select driven, counting down the settle window
// DONE  | result held with out_valid high until out_ready
module alu32_issue_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  alu32_issue_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYCLES);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] opa_q, opa_d;
  logic [31:0] opb_q, opb_d;
  logic [2:0]  sel_q, sel_d;
  logic [31:0] result_q, result_d;
  logic        zero_q, zero_d;
  logic        out_valid_q, out_valid_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      opa_q       <= '0;
      opb_q       <= '0;
      sel_q       <= '0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      opa_q       <= opa_d;
      opb_q       <= opb_d;
      sel_q       <= sel_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Operand/select registers only load on acceptance so the mux never glitches.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    opa_d       = opa_q;
    opb_d       = opb_q;
    sel_d       = sel_q;
    result_d    = result_q;
    zero_d      = zero_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          opa_d   = bus.a;
          opb_d   = bus.b;
          sel_d   = bus.op;
          cnt_d   = SETTLE_LD;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (cnt_q == 4'd1) begin
          result_d    = bus.alu_result;
          zero_d      = (bus.alu_result == 32'd0);
          out_valid_d = 1'b1;
          cnt_d       = 4'd0;
          state_d     = DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.opa       = opa_q;
  assign bus.opb       = opb_q;
  assign bus.sel       = sel_q;
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;
  assign bus.out_valid = out_valid_q;

endmodule

// File: doc/alu32_issue_ctrl.md
# alu32_issue_ctrl

Sequential control stage directly upstream of the 32-bit structural ALU and its 8:1 result-select mux bank. It accepts one operation at a time over a valid/ready handshake and latches the operands and 3-bit op code. It drives the ALU operand buses and the mux select lines S0..S2 stable for a programmable settle window, then registers the mux output with a zero flag. The result is held until the downstream consumer takes it.

## Interface
- SETTLE_CYCLES, 2, cycles the operands/select are held before the mux output is sampled; legal range 1..15.
- clk  in  1  single clock, all state on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  upstream request valid.
- in_ready  out  1  block can accept a request.
- op  in  3  operation code; passed unchanged to the mux select.
- a  in  32  operand A.
- b  in  32  operand B.
- opa  out  32  registered operand A to ALU.
- opb  out  32  registered operand B to ALU.
- sel  out  3  registered mux select; sel[0]→S0, sel[1]→S1, sel[2]→S2.
- alu_result  in  32  output of the 8:1 mux bank (combinational from opa/opb/sel).
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- result  out  32  captured alu_result.
- zero  out  1  result == 0, captured with result.

## Operation
- States: IDLE, EXEC, DONE. Encoding is free.
- in_ready = (state == IDLE), combinational from state. It is 1 during reset.
- IDLE: on an edge with in_valid & in_ready:
  - latch opa←a, opb←b, sel←op;
  - load cnt←SETTLE_CYCLES;
  - go to EXEC.
  - Otherwise hold.
- EXEC: on each edge:
  - if cnt == 1: result←alu_result, zero←(alu_result == 0), out_valid←1, go to DONE;
  - else cnt←cnt−1.
  - in_valid is ignored in EXEC.
- DONE: out_valid stays 1 and result/zero are held.
  - On an edge with out_ready: out_valid←0, go to IDLE.
  - A new request is not accepted in the same edge; in_ready rises the cycle after.
- opa, opb and sel hold their values from acceptance through EXEC and DONE until the next acceptance. The mux inputs never glitch during sampling.
- cnt is 4 bits. No arithmetic on data; result is a straight 32-bit capture.
- op values are not checked; all 8 codes are legal and map 1:1 to mux inputs I0..I7.

## Timing
- Reset (async assert, sync-free release):
  - state=IDLE, cnt=0;
  - opa=opb=0, sel=0, result=0, zero=0, out_valid=0.
- Latency: acceptance edge E → out_valid high after edge E+SETTLE_CYCLES. result is valid in that same cycle.
- Throughput with out_ready held 1: one op per SETTLE_CYCLES+2 cycles.
- SETTLE_CYCLES=1: capture on the first edge after acceptance.
- out_ready already high when DONE is entered: out_valid lasts exactly one cycle.
- out_ready held low: DONE holds indefinitely, and in_ready stays 0.
- Changing a/b/op while in EXEC/DONE has no effect on opa/opb/sel/result.
- Reset asserted mid-EXEC or mid-DONE:
  - all outputs return immediately to their reset values;
  - the pending result is discarded;
  - in_ready=1 after release.

## Test plan
- Bench ALU model: alu_result = opa+opb when sel=2, opa&opb when sel=0, opa−opb when sel=6.
- Reset check: hold rst_n=0 → in_ready=1, out_valid=0, result=0, zero=0, sel=0. Release → same values.
- Basic op: SETTLE_CYCLES=2; send op=2, a=0x0000_0005, b=0x0000_0003 → in_ready drops the next cycle. out_valid rises 2 edges after acceptance with result=0x0000_0008, zero=0, sel=3'b010 held throughout.
- Zero flag and backpressure: op=6, a=b=0x1234_5678, out_ready=0 for 5 cycles → result=0, zero=1. out_valid is held for 5 cycles, and in_valid pulses are ignored. Raise out_ready → out_valid=0 next cycle, in_ready=1.
- Operand isolation: after acceptance of op=0, a=0xFFFF_0000, b=0x0F0F_0F0F, change a/b/op every cycle → result=0x0F0F_0000, and opa/opb unchanged.
- Back-to-back, SETTLE_CYCLES=1, out_ready=1, in_valid=1 continuously with 3 ops → each out_valid is a one-cycle pulse, spaced 3 cycles apart, results in order.
- Mid-operation reset: pulse rst_n low during EXEC of op=2, a=1, b=1 → out_valid never asserts and outputs go to reset values asynchronously. The next op after release completes normally.
